// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Frame-synchronous value updates, per-slot ghost guard and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic        CLK100MHZ,
    input  logic        RSTN,
    input  logic        en,
    input  logic [15:0] val_in,
    input  logic        val_valid,
    output logic        update_ack,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg, idx_next;
    logic [15:0]   shadow_reg, shadow_next;
    logic [15:0]   pend_reg, pend_next;
    logic          pending_reg, pending_next;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          ack_reg, ack_next;
    logic          frame_done_reg, frame_done_next;

    logic [3:0]    digit [4];
    logic [3:0]    lz_dark;
    logic          cnt_last;
    logic          boundary;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi] = shadow_reg[4*gi +: 4];
            if (gi == 0) begin : g_units
                assign lz_dark[gi] = 1'b0;
            end else begin : g_upper
                assign lz_dark[gi] = (LZ_BLANK != 0) && (shadow_reg[15:4*gi] == '0);
            end
        end
    endgenerate

    assign cnt_last = (cnt_reg == CNT_LAST);
    assign boundary = en && (idx_reg == 2'd3) && cnt_last;

    always_comb begin
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        shadow_next     = shadow_reg;
        pend_next       = pend_reg;
        pending_next    = pending_reg;
        an_next         = 4'b1111;
        seg_next        = 7'b1111111;
        ack_next        = 1'b0;
        frame_done_next = 1'b0;

        if (en) begin
            if ((cnt_reg >= CNT_BLANK) && !lz_dark[idx_reg]) begin
                an_next  = ~(4'b0001 << idx_reg);
                seg_next = decode(digit[idx_reg]);
            end
            if (cnt_last) begin
                cnt_next = '0;
                idx_next = idx_reg + 2'd1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
            frame_done_next = boundary;
        end

        // A strobe landing on the boundary itself is newer than anything pending.
        if (boundary && val_valid) begin
            shadow_next  = val_in;
            pending_next = 1'b0;
            ack_next     = 1'b1;
        end else if (boundary && pending_reg) begin
            shadow_next  = pend_reg;
            pending_next = 1'b0;
            ack_next     = 1'b1;
        end else if (val_valid) begin
            pend_next    = val_in;
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!RSTN) begin
            cnt_reg        <= '0;
            idx_reg        <= 2'd0;
            shadow_reg     <= 16'h0000;
            pend_reg       <= 16'h0000;
            pending_reg    <= 1'b0;
            an_reg         <= 4'b1111;
            seg_reg        <= 7'b1111111;
            ack_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shadow_reg     <= shadow_next;
            pend_reg       <= pend_next;
            pending_reg    <= pending_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            ack_reg        <= ack_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign update_ack = ack_reg;
    assign frame_done = frame_done_reg;

endmodule
